// File: rtl/sio_niu_pkt_checker.sv
// Passive protocol checker and packet statistics for the SIU-to-NIU DMA-response bus.
// Lane parity checking is compiled in only when SIO_NIU_PAR_CHK_EN is defined.
module sio_niu_pkt_checker #(
    parameter int DATA_W        = 128,
    parameter int PAR_W         = DATA_W / 16,
    parameter int PAYLOAD_BEATS = 4,
    parameter int DREQ_LAT      = 1,
    parameter int PAR_ODD       = 0,
    parameter int CNT_W         = 32
) (
    input  logic              iol2clk,
    input  logic              reset,
    input  logic              mon_en,
    input  logic              sio_niu_hdr_vld,
    input  logic              sio_niu_datareq,
    input  logic [DATA_W-1:0] sio_niu_data,
    input  logic [PAR_W-1:0]  sio_niu_parity,
    output logic              beat_vld,
    output logic [3:0]        beat_idx,
    output logic [CNT_W-1:0]  hdr_cnt,
    output logic [CNT_W-1:0]  payload_cnt,
    output logic [CNT_W-1:0]  ack_cnt,
    output logic [3:0]        err_pulse,
    output logic [3:0]        err_status
);

    // Bus handshake: a header is a single cycle with sio_niu_hdr_vld=1; no back-pressure exists,
    // so every header or payload beat is consumed in the cycle it is presented.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(PAYLOAD_BEATS - 1);
    localparam logic [1:0] LAST_WAIT = 2'(DREQ_LAT - 2);

    state_t             state_q, state_d;
    logic [1:0]         wait_q, wait_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   hdr_cnt_q, payload_cnt_q, ack_cnt_q;
    logic [3:0]         err_pulse_q, err_status_q, err_d;
    logic               hdr_inc, ack_inc, pay_inc;
    logic               par_bad;

`ifdef SIO_NIU_PAR_CHK_EN
    logic [PAR_W-1:0] lane_exp;

    always_comb begin
        lane_exp = '0;
        for (int i = 0; i < PAR_W; i++) begin
            lane_exp[i] = (^sio_niu_data[16*i +: 16]) ^ 1'(PAR_ODD);
        end
    end

    assign par_bad = |(lane_exp ^ sio_niu_parity);
`else
    logic unused_par_inputs;

    assign unused_par_inputs = ^{sio_niu_parity, sio_niu_data};
    assign par_bad           = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        hdr_inc = 1'b0;
        ack_inc = 1'b0;
        pay_inc = 1'b0;
        err_d   = 4'b0000;
        case (state_q)
            S_IDLE: begin
                // mon_en only gates the start of a packet; once in flight it is ignored.
                if (mon_en) begin
                    if (sio_niu_hdr_vld) begin
                        hdr_inc  = 1'b1;
                        err_d[0] = par_bad;
                        if (sio_niu_datareq) begin
                            idx_d   = 4'd0;
                            wait_d  = 2'd0;
                            state_d = (DREQ_LAT > 1) ? S_WAIT : S_PAYLOAD;
                        end else begin
                            ack_inc = 1'b1;
                        end
                    end else begin
                        err_d[2] = sio_niu_datareq;
                    end
                end
            end
            S_WAIT: begin
                err_d[1] = sio_niu_hdr_vld;
                err_d[2] = sio_niu_datareq & ~sio_niu_hdr_vld;
                if (wait_q == LAST_WAIT) begin
                    state_d = S_PAYLOAD;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_PAYLOAD: begin
                err_d[0] = par_bad;
                err_d[1] = sio_niu_hdr_vld;
                err_d[2] = sio_niu_datareq & ~sio_niu_hdr_vld;
                if (idx_q == LAST_IDX) begin
                    pay_inc = 1'b1;
                    idx_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge iol2clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_q        <= 2'd0;
            idx_q         <= 4'd0;
            hdr_cnt_q     <= '0;
            payload_cnt_q <= '0;
            ack_cnt_q     <= '0;
            err_pulse_q   <= 4'b0000;
            err_status_q  <= 4'b0000;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            idx_q        <= idx_d;
            err_pulse_q  <= err_d;
            err_status_q <= err_status_q | err_d;
            if (hdr_inc) hdr_cnt_q     <= sat_inc(hdr_cnt_q);
            if (ack_inc) ack_cnt_q     <= sat_inc(ack_cnt_q);
            if (pay_inc) payload_cnt_q <= sat_inc(payload_cnt_q);
        end
    end

    assign beat_vld    = (state_q == S_PAYLOAD);
    assign beat_idx    = idx_q;
    assign hdr_cnt     = hdr_cnt_q;
    assign payload_cnt = payload_cnt_q;
    assign ack_cnt     = ack_cnt_q;
    assign err_pulse   = err_pulse_q;
    assign err_status  = err_status_q;

endmodule

// File: tb/tb_sio_niu_pkt_checker.sv
// Bench for sio_niu_pkt_checker: per-cycle vector table on a default instance plus
// hand sequences for reset abort, WAIT-state timing and counter saturation.
module tb_sio_niu_pkt_checker;

`ifdef SIO_NIU_PAR_CHK_EN
    localparam logic [3:0] PMASK = 4'b1111;
`else
    localparam logic [3:0] PMASK = 4'b1110;
`endif

    logic         clk, rst;
    // default instance
    logic         men, hv, dr;
    logic [127:0] data;
    logic [7:0]   par;
    logic         bv;
    logic [3:0]   bidx, errp, errs;
    logic [31:0]  hcnt, pcnt, acnt;
    // DREQ_LAT=3, PAYLOAD_BEATS=8, 4-bit counters
    logic         men1, hv1, dr1;
    logic [127:0] data1;
    logic [7:0]   par1;
    logic         bv1;
    logic [3:0]   bidx1, errp1, errs1;
    logic [3:0]   hcnt1, pcnt1, acnt1;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic       men, hv, dr, bad;
        logic       exp_bv;
        logic [3:0] exp_idx;
        logic [3:0] exp_err;
        logic       chk;
        int         hdr, pay, ack;
        logic [3:0] st;
    } vec_t;

    vec_t tbl[$];

    sio_niu_pkt_checker dut0 (
        .iol2clk(clk), .reset(rst), .mon_en(men),
        .sio_niu_hdr_vld(hv), .sio_niu_datareq(dr),
        .sio_niu_data(data), .sio_niu_parity(par),
        .beat_vld(bv), .beat_idx(bidx),
        .hdr_cnt(hcnt), .payload_cnt(pcnt), .ack_cnt(acnt),
        .err_pulse(errp), .err_status(errs)
    );

    sio_niu_pkt_checker #(.PAYLOAD_BEATS(8), .DREQ_LAT(3), .CNT_W(4)) dut1 (
        .iol2clk(clk), .reset(rst), .mon_en(men1),
        .sio_niu_hdr_vld(hv1), .sio_niu_datareq(dr1),
        .sio_niu_data(data1), .sio_niu_parity(par1),
        .beat_vld(bv1), .beat_idx(bidx1),
        .hdr_cnt(hcnt1), .payload_cnt(pcnt1), .ack_cnt(acnt1),
        .err_pulse(errp1), .err_status(errs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] good_par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    function automatic vec_t row(input logic m, input logic h, input logic d, input logic b,
                                 input logic ebv, input logic [3:0] eidx, input logic [3:0] eerr);
        vec_t v;
        v.men = m; v.hv = h; v.dr = d; v.bad = b;
        v.exp_bv = ebv; v.exp_idx = eidx; v.exp_err = eerr;
        v.chk = 1'b0; v.hdr = 0; v.pay = 0; v.ack = 0; v.st = 4'b0000;
        return v;
    endfunction

    function automatic vec_t idle_beat(input logic [3:0] eidx);
        return row(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, eidx, 4'b0000);
    endfunction

    function automatic vec_t chk(input int h, input int p, input int a, input logic [3:0] s);
        vec_t v;
        v = row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000);
        v.chk = 1'b1; v.hdr = h; v.pay = p; v.ack = a; v.st = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive0(input logic m, input logic h, input logic d, input logic b);
        men  = m;
        hv   = h;
        dr   = d;
        data = {$urandom, $urandom, $urandom, $urandom};
        par  = good_par(data) ^ (b ? 8'h08 : 8'h00);
    endtask

    task automatic drive1(input logic h, input logic d);
        hv1   = h;
        dr1   = d;
        data1 = {$urandom, $urandom, $urandom, $urandom};
        par1  = good_par(data1);
    endtask

    // One cycle on dut0: compare outputs of this cycle, then present this cycle's inputs.
    task automatic step(input vec_t v);
        logic [3:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("err_pulse", {28'd0, errp}, {28'd0, e});
        end
        check("beat_vld", {31'd0, bv}, {31'd0, v.exp_bv});
        if (v.exp_bv) check("beat_idx", {28'd0, bidx}, {28'd0, v.exp_idx});
        if (v.chk) begin
            check("hdr_cnt", hcnt, v.hdr);
            check("payload_cnt", pcnt, v.pay);
            check("ack_cnt", acnt, v.ack);
            check("err_status", {28'd0, errs}, {28'd0, v.st & PMASK});
        end
        drive0(v.men, v.hv, v.dr, v.bad);
        exp_q.push_back(v.exp_err & PMASK);
    endtask

    initial begin
        rst = 1'b1;
        drive0(1'b1, 1'b0, 1'b0, 1'b0);
        men1 = 1'b1;
        drive1(1'b0, 1'b0);

        // single payload packet
        tbl.push_back(row(1, 1, 1, 0, 0, 0, 4'b0000));
        for (int i = 0; i < 4; i++) tbl.push_back(idle_beat(4'(i)));
        tbl.push_back(chk(1, 1, 0, 4'b0000));
        // two back-to-back write-acks
        tbl.push_back(row(1, 1, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(row(1, 1, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(chk(3, 1, 2, 4'b0000));
        // overlap at T+2, header at T+5 accepted
        tbl.push_back(row(1, 1, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(idle_beat(4'd0));
        tbl.push_back(row(1, 1, 0, 0, 1, 4'd1, 4'b0010));
        tbl.push_back(idle_beat(4'd2));
        tbl.push_back(idle_beat(4'd3));
        tbl.push_back(row(1, 1, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(chk(5, 2, 3, 4'b0010));
        // lane 3 parity flipped on beat 2
        tbl.push_back(row(1, 1, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(idle_beat(4'd0));
        tbl.push_back(idle_beat(4'd1));
        tbl.push_back(row(1, 0, 0, 1, 1, 4'd2, 4'b0001));
        tbl.push_back(idle_beat(4'd3));
        tbl.push_back(chk(6, 3, 3, 4'b0011));
        // orphan datareq in IDLE
        tbl.push_back(row(1, 0, 1, 0, 0, 0, 4'b0100));
        tbl.push_back(chk(6, 3, 3, 4'b0111));
        // monitor disabled: header, bad parity and orphan all ignored
        tbl.push_back(row(0, 1, 1, 1, 0, 0, 4'b0000));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(chk(6, 3, 3, 4'b0111));
        // bad header parity, mon_en dropped mid-packet, overlap on last beat, back-to-back packet
        tbl.push_back(row(1, 1, 1, 1, 0, 0, 4'b0001));
        tbl.push_back(row(0, 0, 0, 0, 1, 4'd0, 4'b0000));
        tbl.push_back(row(0, 0, 0, 0, 1, 4'd1, 4'b0000));
        tbl.push_back(row(0, 0, 0, 0, 1, 4'd2, 4'b0000));
        tbl.push_back(row(1, 1, 1, 0, 1, 4'd3, 4'b0010));
        tbl.push_back(row(1, 1, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(idle_beat(4'd0));
        tbl.push_back(row(1, 0, 1, 1, 1, 4'd1, 4'b0101));
        tbl.push_back(idle_beat(4'd2));
        tbl.push_back(idle_beat(4'd3));
        tbl.push_back(chk(8, 5, 3, 4'b0111));
        tbl.push_back(row(1, 0, 0, 0, 0, 0, 4'b0000));

        // reset values
        repeat (3) @(negedge clk);
        check("rst beat_vld", {31'd0, bv}, 32'd0);
        check("rst beat_idx", {28'd0, bidx}, 32'd0);
        check("rst hdr_cnt", hcnt, 32'd0);
        check("rst payload_cnt", pcnt, 32'd0);
        check("rst ack_cnt", acnt, 32'd0);
        check("rst err_pulse", {28'd0, errp}, 32'd0);
        check("rst err_status", {28'd0, errs}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // reset asserted at T+2 of a payload packet aborts it
        step(row(1, 1, 1, 0, 0, 0, 4'b0000));
        step(idle_beat(4'd0));
        @(negedge clk);
        check("abort err_pulse", {28'd0, errp}, {28'd0, exp_q.pop_front()});
        check("abort beat_idx T+2", {28'd0, bidx}, 32'd1);
        drive0(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("abort beat_vld", {31'd0, bv}, 32'd0);
        check("abort state", {30'd0, dut0.state_q}, 32'd0);
        check("abort payload_cnt", pcnt, 32'd0);
        check("abort hdr_cnt", hcnt, 32'd0);
        check("abort err_pulse after", {28'd0, errp}, 32'd0);
        check("abort err_status", {28'd0, errs}, 32'd0);
        rst = 1'b0;
        exp_q.delete();

        // DREQ_LAT=3, 8 beats, with an overlapping header during WAIT
        @(negedge clk);
        drive1(1'b1, 1'b1);
        for (int t = 1; t <= 11; t++) begin
            @(negedge clk);
            check("l3 beat_vld", {31'd0, bv1}, {31'd0, (t >= 3 && t <= 10)});
            if (t >= 3 && t <= 10) check("l3 beat_idx", {28'd0, bidx1}, t - 3);
            if (t == 2) check("l3 err_pulse overlap", {28'd0, errp1}, 32'd2);
            if (t == 3) check("l3 err_pulse clear", {28'd0, errp1}, 32'd0);
            if (t == 1) drive1(1'b1, 1'b0);
            else drive1(1'b0, 1'b0);
        end
        check("l3 hdr_cnt", {28'd0, hcnt1}, 32'd1);
        check("l3 payload_cnt", {28'd0, pcnt1}, 32'd1);

        // 16 more back-to-back packets: counters must stop at all-ones
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive1(1'b1, 1'b1);
            for (int t = 1; t <= 10; t++) begin
                @(negedge clk);
                if (k == 7) begin
                    check("sat beat_vld", {31'd0, bv1}, {31'd0, (t >= 3)});
                    if (t >= 3) check("sat beat_idx", {28'd0, bidx1}, t - 3);
                end
                drive1(1'b0, 1'b0);
            end
        end
        @(negedge clk);
        check("sat hdr_cnt", {28'd0, hcnt1}, 32'd15);
        check("sat payload_cnt", {28'd0, pcnt1}, 32'd15);
        for (int k = 0; k < 17; k++) begin
            drive1(1'b1, 1'b0);
            @(negedge clk);
        end
        drive1(1'b0, 1'b0);
        @(negedge clk);
        check("sat ack_cnt", {28'd0, acnt1}, 32'd15);
        check("sat hdr_cnt hold", {28'd0, hcnt1}, 32'd15);
        check("l3 err_status", {28'd0, errs1}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
